// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: opcodes, branch fun3 codes and resolver state encoding
package branch_resolver_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {IDLE, WAIT_OPS, RESOLVE, REPORT} state_e;

    function automatic logic is_cti(input logic [6:0] op);
        return op == OP_BRANCH || op == OP_JAL || op == OP_JALR;
    endfunction

endpackage

// File: rtl/branch_resolver_compare.sv
// br_compare: six-way signed/unsigned branch condition with illegal fun3 flag
module br_compare
    import branch_resolver_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  fun3,
    output logic        cond,
    output logic        illegal
);

    // Evaluate the branch condition; fun3 010/011 are not branch encodings
    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (fun3)
            F3_BEQ:  cond = a == b;
            F3_BNE:  cond = a != b;
            F3_BLT:  cond = $signed(a) < $signed(b);
            F3_BGE:  cond = $signed(a) >= $signed(b);
            F3_BLTU: cond = a < b;
            F3_BGEU: cond = a >= b;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves BRANCH/JAL/JALR next PC and link write-back
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int LINK_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  fun3,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    input  logic [31:0] opc,
    input  logic [31:0] rs1_val,
    input  logic        rs1_rdy,
    input  logic [31:0] rs2_val,
    input  logic        rs2_rdy,
    input  logic        flush,
    output logic [31:0] npc,
    output logic        get_npc,
    output logic        taken,
    output logic        err,
    output logic        link_we,
    output logic [4:0]  link_rd,
    output logic [31:0] link_val
);

    state_e      state_q, state_d;
    logic [6:0]  opcode_q;
    logic [2:0]  fun3_q;
    logic [4:0]  rd_q;
    logic [31:0] imm_q, opc_q, rs1_q, rs2_q;
    logic [31:0] npc_q, link_val_q;
    logic [4:0]  link_rd_q;
    logic        get_npc_q, taken_q, err_q, link_we_q;
    logic        accept, ops_rdy, latch_ops, rep;
    logic        cond, illegal;
    logic        is_br, is_jalr, want, mis;
    logic [31:0] seq, target, npc_d;
    logic        taken_d, err_d, link_we_d;

    br_compare u_cmp (
        .a      (rs1_q),
        .b      (rs2_q),
        .fun3   (fun3_q),
        .cond   (cond),
        .illegal(illegal)
    );

    assign accept    = state_q == IDLE && br_valid && is_cti(opcode);
    assign ops_rdy   = opcode_q == OP_JAL || (rs1_rdy && (opcode_q == OP_JALR || rs2_rdy));
    assign latch_ops = state_q == WAIT_OPS && !flush && ops_rdy;
    assign rep       = state_q == RESOLVE && !flush;

    // Next-state: flush only aborts while operands are pending or resolving
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = accept ? WAIT_OPS : IDLE;
            WAIT_OPS: state_d = flush ? IDLE : (ops_rdy ? RESOLVE : WAIT_OPS);
            RESOLVE:  state_d = flush ? IDLE : REPORT;
            default:  state_d = IDLE;
        endcase
    end

    // Resolution: a misaligned taken target falls back to the sequential PC
    always_comb begin
        is_br     = opcode_q == OP_BRANCH;
        is_jalr   = opcode_q == OP_JALR;
        seq       = opc_q + 32'd4;
        target    = is_jalr ? ((rs1_q + imm_q) & ~32'd1) : (opc_q + imm_q);
        want      = !is_br || (cond && !illegal);
        mis       = want && target[1];
        err_d     = (is_br && illegal) || mis;
        taken_d   = want && !mis;
        npc_d     = taken_d ? target : seq;
        link_we_d = (LINK_EN != 0) && !is_br && !err_d && rd_q != 5'd0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Instruction fields captured on accept, operands captured once ready
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q <= '0;
            fun3_q   <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            opc_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
        end else begin
            if (accept) begin
                opcode_q <= opcode;
                fun3_q   <= fun3;
                rd_q     <= rd;
                imm_q    <= imm;
                opc_q    <= opc;
            end
            if (latch_ops) begin
                rs1_q <= rs1_val;
                rs2_q <= rs2_val;
            end
        end
    end

    // Report registers: strobes live only in REPORT, values hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            npc_q      <= '0;
            get_npc_q  <= 1'b0;
            taken_q    <= 1'b0;
            err_q      <= 1'b0;
            link_we_q  <= 1'b0;
            link_rd_q  <= '0;
            link_val_q <= '0;
        end else begin
            get_npc_q <= rep;
            taken_q   <= rep && taken_d;
            err_q     <= rep && err_d;
            link_we_q <= rep && link_we_d;
            if (rep) npc_q <= npc_d;
            if (rep && link_we_d) begin
                link_rd_q  <= rd_q;
                link_val_q <= seq;
            end
        end
    end

    assign br_ready = state_q == IDLE;
    assign npc      = npc_q;
    assign get_npc  = get_npc_q;
    assign taken    = taken_q;
    assign err      = err_q;
    assign link_we  = link_we_q;
    assign link_rd  = link_rd_q;
    assign link_val = link_val_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed transactions checked against a cycle-scheduled model
module tb_branch_resolver;

    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  fun3 = '0;
    logic [4:0]  rd = '0;
    logic [31:0] imm = '0;
    logic [31:0] opc = '0;
    logic [31:0] rs1_val = '0;
    logic        rs1_rdy = 1'b0;
    logic [31:0] rs2_val = '0;
    logic        rs2_rdy = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] npc;
    logic        get_npc, taken, err, link_we;
    logic [4:0]  link_rd;
    logic [31:0] link_val;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic en = 1'b0;
    logic [11:0] ix;

    bit          exp_busy[4096];
    bit          exp_strobe[4096];
    bit          exp_taken[4096];
    bit          exp_err[4096];
    bit          exp_lwe[4096];
    logic [31:0] exp_npc[4096];
    logic [31:0] exp_lval[4096];
    logic [4:0]  exp_lrd[4096];

    branch_resolver #(.LINK_EN(1)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
        .opcode(opcode), .fun3(fun3), .rd(rd), .imm(imm), .opc(opc),
        .rs1_val(rs1_val), .rs1_rdy(rs1_rdy), .rs2_val(rs2_val), .rs2_rdy(rs2_rdy),
        .flush(flush), .npc(npc), .get_npc(get_npc), .taken(taken), .err(err),
        .link_we(link_we), .link_rd(link_rd), .link_val(link_val)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign ix = cyc[11:0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Architectural outcome of one control transfer
    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rdv,
                         input logic [31:0] iv, input logic [31:0] ov, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] n, output logic t,
                         output logic e, output logic lw, output logic [31:0] lv);
        logic c, bad, want;
        logic [31:0] tgt;
        bad = 1'b0;
        case (f3)
            3'b000:  c = a == b;
            3'b001:  c = a != b;
            3'b100:  c = $signed(a) < $signed(b);
            3'b101:  c = $signed(a) >= $signed(b);
            3'b110:  c = a < b;
            3'b111:  c = a >= b;
            default: begin c = 1'b0; bad = 1'b1; end
        endcase
        if (op == BR) begin
            tgt  = ov + iv;
            want = c && !bad;
        end else begin
            bad  = 1'b0;
            tgt  = (op == JALR) ? ((a + iv) & 32'hFFFF_FFFE) : ov + iv;
            want = 1'b1;
        end
        e  = bad || (want && tgt[1]);
        t  = want && !tgt[1];
        n  = t ? tgt : ov + 32'd4;
        lw = op != BR && !e && rdv != 5'd0;
        lv = ov + 32'd4;
    endtask

    task automatic pin(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rdv, input logic [31:0] iv, input logic [31:0] ov,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] en_npc,
                       input logic [2:0] ete, input logic [31:0] elv);
        logic [31:0] n, lv;
        logic t, e, lw;
        model(op, f3, rdv, iv, ov, a, b, n, t, e, lw, lv);
        chk({nm, "_npc"}, n, en_npc);
        chk({nm, "_flags"}, 32'({t, e, lw}), 32'(ete));
        if (lw) chk({nm, "_lval"}, lv, elv);
    endtask

    // One instruction: schedule expectations, then drive it cycle by cycle.
    // fo = cycle offset from accept at which flush pulses (-1 for none).
    task automatic txn(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rdv,
                       input logic [31:0] iv, input logic [31:0] ov, input logic [31:0] a,
                       input logic [31:0] b, input int stall, input int fo);
        int t, r, ab, last, st;
        logic [31:0] n, lv;
        logic tk, e, lw;
        @(posedge clk); #1;
        t = cyc;
        st = (op == JAL) ? 0 : stall;
        br_valid = 1'b1; opcode = op; fun3 = f3; rd = rdv; imm = iv; opc = ov;
        rs1_val = ~a; rs2_val = ~b; rs1_rdy = 1'b0; rs2_rdy = 1'b0; flush = (fo == 0);
        r = t + 3 + st;
        if (op == BR || op == JAL || op == JALR) begin
            ab = (fo >= 1 && fo <= 2 + st) ? t + fo : 0;
            last = (ab != 0) ? ab : r;
            for (int c = t + 1; c <= last; c++) exp_busy[12'(c)] = 1'b1;
            if (ab == 0) begin
                model(op, f3, rdv, iv, ov, a, b, n, tk, e, lw, lv);
                exp_strobe[12'(r)] = 1'b1;
                exp_npc[12'(r)]    = n;
                exp_taken[12'(r)]  = tk;
                exp_err[12'(r)]    = e;
                exp_lwe[12'(r)]    = lw;
                exp_lrd[12'(r)]    = rdv;
                exp_lval[12'(r)]   = lv;
            end
        end
        for (int k = 1; k <= st + 4; k++) begin
            @(posedge clk); #1;
            br_valid = 1'b0; opcode = 7'h0; fun3 = ~f3; rd = ~rdv; imm = ~iv; opc = ~ov;
            rs1_rdy = (k == st + 1); rs2_rdy = (k == st + 1);
            rs1_val = (k == st + 1) ? a : ~a;
            rs2_val = (k == st + 1) ? b : ~b;
            flush = (k == fo);
        end
        flush = 1'b0; rs1_rdy = 1'b0; rs2_rdy = 1'b0;
    endtask

    // Per-cycle comparison against the scheduled expectations
    always @(negedge clk) begin
        if (en) begin
            chk("br_ready", 32'(br_ready), 32'(!exp_busy[ix]));
            chk("get_npc", 32'(get_npc), 32'(exp_strobe[ix]));
            chk("taken", 32'(taken), 32'(exp_taken[ix]));
            chk("err", 32'(err), 32'(exp_err[ix]));
            chk("link_we", 32'(link_we), 32'(exp_lwe[ix]));
            if (exp_strobe[ix]) chk("npc", npc, exp_npc[ix]);
            if (exp_lwe[ix]) begin
                chk("link_rd", 32'(link_rd), 32'(exp_lrd[ix]));
                chk("link_val", link_val, exp_lval[ix]);
            end
        end
    end

    initial begin
        int t;
        pin("m_beq", BR, 3'b000, 5'd0, 32'h20, 32'h100, 32'd5, 32'd5, 32'h120, 3'b100, 32'h0);
        pin("m_blt", BR, 3'b100, 5'd0, 32'h40, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h240, 3'b100, 32'h0);
        pin("m_bltu", BR, 3'b110, 5'd0, 32'h40, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h204, 3'b000, 32'h0);
        pin("m_jalr", JALR, 3'b000, 5'd1, 32'h1, 32'h40, 32'h203, 32'h0, 32'h204, 3'b101, 32'h44);
        pin("m_jalwrap", JAL, 3'b000, 5'd1, 32'h8, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h4, 3'b101, 32'h0);
        pin("m_jalmis", JAL, 3'b000, 5'd1, 32'h6, 32'h0, 32'h0, 32'h0, 32'h4, 3'b010, 32'h0);
        pin("m_f3ill", BR, 3'b010, 5'd0, 32'h20, 32'h500, 32'h0, 32'h0, 32'h504, 3'b010, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_br_ready", 32'(br_ready), 32'd1);
        chk("rst_get_npc", 32'(get_npc), 32'd0);
        chk("rst_npc", npc, 32'd0);
        chk("rst_flags", 32'({taken, err, link_we}), 32'd0);
        chk("rst_link_rd", 32'(link_rd), 32'd0);
        chk("rst_link_val", link_val, 32'd0);
        rst = 1'b0;
        en  = 1'b1;

        txn(BR,   3'b000, 5'd0, 32'h20, 32'h100, 32'd5, 32'd5, 0, -1);
        txn(BR,   3'b001, 5'd0, 32'h10, 32'h300, 32'd5, 32'd5, 0, -1);
        txn(BR,   3'b100, 5'd0, 32'h40, 32'h200, 32'hFFFF_FFFF, 32'd1, 0, -1);
        txn(BR,   3'b110, 5'd0, 32'h40, 32'h200, 32'hFFFF_FFFF, 32'd1, 1, -1);
        txn(BR,   3'b101, 5'd0, 32'hFFFF_FFF8, 32'h400, 32'd1, 32'hFFFF_FFFF, 0, -1);
        txn(BR,   3'b111, 5'd0, 32'h40, 32'h400, 32'd1, 32'hFFFF_FFFF, 2, -1);
        txn(JALR, 3'b000, 5'd1, 32'h1, 32'h40, 32'h203, 32'h0, 4, -1);
        txn(JAL,  3'b000, 5'd1, 32'h8, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, -1);
        txn(JAL,  3'b000, 5'd5, 32'h6, 32'h0, 32'h0, 32'h0, 0, -1);
        txn(JAL,  3'b000, 5'd0, 32'h100, 32'h80, 32'h0, 32'h0, 0, -1);
        txn(BR,   3'b010, 5'd0, 32'h20, 32'h500, 32'd5, 32'd5, 0, -1);
        txn(BR,   3'b000, 5'd0, 32'h22, 32'h100, 32'd7, 32'd7, 0, -1);
        txn(7'b0110011, 3'b000, 5'd3, 32'h20, 32'h600, 32'd1, 32'd1, 0, -1);
        txn(BR,   3'b000, 5'd0, 32'h20, 32'h700, 32'd5, 32'd5, 2, 1);
        txn(BR,   3'b000, 5'd0, 32'h20, 32'h800, 32'd5, 32'd5, 0, 2);
        txn(JALR, 3'b000, 5'd9, 32'h10, 32'h900, 32'h1000, 32'h0, 0, 3);
        txn(BR,   3'b000, 5'd0, 32'h20, 32'h100, 32'd5, 32'd5, 0, 0);

        @(posedge clk); #1;
        t = cyc;
        br_valid = 1'b1; opcode = BR; fun3 = 3'b000; imm = 32'h20; opc = 32'hA00;
        rs1_val = 32'd5; rs2_val = 32'd5;
        exp_busy[12'(t + 1)] = 1'b1;
        exp_busy[12'(t + 2)] = 1'b1;
        @(posedge clk); #1;
        br_valid = 1'b0; rs1_rdy = 1'b1; rs2_rdy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; rs1_rdy = 1'b0; rs2_rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstres_npc", npc, 32'd0);
        chk("rstres_link_val", link_val, 32'd0);
        chk("rstres_link_rd", 32'(link_rd), 32'd0);
        chk("rstres_br_ready", 32'(br_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter LINK_EN, default 1, meaning link write-back is enabled; 0 forces link_we low.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: br_valid  in  1  decode presents a control-transfer instruction.
REQ-005 SHALL have ports: br_ready  out  1  resolver idle, accepts br_valid.
REQ-006 SHALL have ports: opcode  in  7; fun3  in  3; rd  in  5; imm  in  32; opc  in  32  (PC of the instruction).
REQ-007 SHALL have ports: rs1_val  in  32; rs1_rdy  in  1; rs2_val  in  32; rs2_rdy  in  1  (register operands, with ready flags).
REQ-008 SHALL have ports: flush  in  1  abandons the in-flight resolution.
REQ-009 SHALL have ports: npc  out  32  resolved next PC; get_npc  out  1  one-cycle strobe to the fetch controller.
REQ-010 SHALL have ports: taken  out  1; err  out  1; link_we  out  1; link_rd  out  5; link_val  out  32.

Function
REQ-011 SHALL implement states IDLE, WAIT_OPS, RESOLVE, REPORT; br_ready=1 only in IDLE.
REQ-012 SHALL accept in IDLE when br_valid=1 and opcode is 1100011 (BRANCH), 1101111 (JAL) or 1100111 (JALR); it SHALL latch opcode, fun3, rd, imm and opc, then go to WAIT_OPS.
REQ-013 SHALL ignore br_valid with any other opcode: stay in IDLE, no outputs.
REQ-014 SHALL leave WAIT_OPS for RESOLVE once the required operands are ready: BRANCH needs rs1_rdy and rs2_rdy; JALR needs rs1_rdy; JAL needs none. It SHALL latch rs1_val and rs2_val on that edge.
REQ-015 SHALL compute in RESOLVE, registered into REPORT:
- BEQ 000, BNE 001, BLT 100 and BGE 101 compare signed.
- BLTU 110 and BGEU 111 compare unsigned.
- BRANCH: taken → npc=opc+imm; not taken → npc=opc+4.
- JAL: npc=opc+imm.
- JALR: npc=(rs1+imm) with bit0 cleared.
- JAL and JALR: taken=1.
REQ-016 SHALL perform all address arithmetic modulo 2^32 (wrap-around, no error).
REQ-017 SHALL, for BRANCH with fun3 010 or 011, set err=1, taken=0, npc=opc+4.
REQ-018 SHALL, when a taken target has bit1 set (misaligned), set err=1, taken=0, npc=opc+4, link_we=0.
REQ-019 SHALL, in REPORT, assert get_npc, npc, taken and err for exactly one cycle, then return to IDLE.
REQ-020 SHALL, in REPORT for JAL/JALR without err and with LINK_EN=1, drive link_we=1, link_rd=rd, link_val=opc+4; link_we=0 when rd=0.
REQ-021 SHALL meet this latency: accept at cycle T with operands ready at T+1 → get_npc high in cycle T+3; each stalled WAIT_OPS cycle adds one.
REQ-022 SHALL, on flush in WAIT_OPS or RESOLVE, return to IDLE next cycle without get_npc or link_we; flush in IDLE or REPORT SHALL have no effect.
REQ-023 SHALL hold get_npc, link_we, taken and err at 0 outside REPORT; npc, link_rd and link_val SHALL hold their last values.

Reset
REQ-024 SHALL, while rst=1 at a clk edge, enter IDLE and clear npc, get_npc, taken, err, link_we, link_rd and link_val to 0, overriding all inputs including an in-flight resolution.
REQ-025 SHALL have br_ready=1 on the first cycle after rst deasserts.

Structure
REQ-026 SHALL take opcode constants (OP_BRANCH, OP_JAL, OP_JALR), fun3 codes and state encodings from the shared defines header used by the decoder and fetch controller.
REQ-027 SHALL place the six-way signed/unsigned compare in one combinational sub-module, br_compare (inputs a, b, fun3; outputs cond, illegal).

Verification
REQ-028 SHALL cover BEQ taken: opc=0x100, imm=0x20, rs1=rs2=5, operands ready → get_npc at T+3, npc=0x120, taken=1.
REQ-029 SHALL cover BLT vs BLTU: rs1=0xFFFFFFFF, rs2=1 → BLT taken (npc=opc+imm), BLTU not taken (npc=opc+4).
REQ-030 SHALL cover JALR: rs1_rdy low 4 cycles, rs1=0x203, imm=0x1, rd=1, opc=0x40 → get_npc at T+7, npc=0x204, link_we=1, link_rd=1, link_val=0x44.
REQ-031 SHALL cover JAL wrap and misalignment: opc=0xFFFFFFFC, imm=8 → npc=0x4; opc=0, imm=6 → err=1, npc=0x4, link_we=0.
REQ-032 SHALL cover flush and reset: flush in WAIT_OPS → no get_npc, br_ready=1 next cycle; rst in RESOLVE → outputs 0, IDLE.
REQ-033 SHALL cover illegal inputs: fun3=010 → err=1, npc=opc+4; br_valid with opcode 0110011 → not accepted, no strobe.
